axi4lite_slave_regs: RTL and testbench
======================================

# axi4lite_slave_regs

AXI4-Lite responder (slave) fronting a small register file of 2^ADDR_WIDTH registers, each DATA_WIDTH bits. It is the far end of the AXI4-Lite master used in `tt_um_axi4lite_top`: it accepts AW/W/AR transactions, updates or returns register contents, and issues B/R responses. Register contents are also exported flat for use by surrounding fabric logic.

## Interface
Parameters:
- ADDR_WIDTH, 2, register index width; addresses are word indices, not byte addresses.
- DATA_WIDTH, 8, register and data-bus width; must be a multiple of 8.
- RO_MASK, {2^ADDR_WIDTH{1'b0}}, bit i set makes register i read-only.

Ports (one clock; reset asynchronous, active-low):
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_awvalid / s_awready  in / out  1  write-address handshake.
- s_awaddr  in  ADDR_WIDTH  write register index.
- s_awprot  in  3  accepted and ignored.
- s_wvalid / s_wready  in / out  1  write-data handshake.
- s_wdata  in  DATA_WIDTH  write data.
- s_wstrb  in  DATA_WIDTH/8  byte-lane enables.
- s_bvalid / s_bready  out / in  1  write-response handshake.
- s_bresp  out  2  00 OKAY, 10 SLVERR.
- s_arvalid / s_arready  in / out  1  read-address handshake.
- s_araddr  in  ADDR_WIDTH  read register index.
- s_arprot  in  3  accepted and ignored.
- s_rvalid / s_rready  out / in  1  read-data handshake.
- s_rdata  out  DATA_WIDTH  read data.
- s_rresp  out  2  always 00 OKAY.
- reg_out  out  DATA_WIDTH*2^ADDR_WIDTH  all registers, reg i at bits [i*DATA_WIDTH +: DATA_WIDTH].

## Operation
- Write path has two one-entry holding buffers, AW (addr) and W (data+strb), each with a full flag.
- s_awready = !aw_full; s_wready = !w_full. AW and W are accepted independently, in either order or in the same cycle.
- Commit condition: aw_full && w_full && !s_bvalid. On the commit edge:
  - Target not RO: update each byte lane whose strb bit is 1. bresp=OKAY.
  - Target RO: register unchanged. bresp=SLVERR.
  - Set s_bvalid; clear both full flags.
- s_bvalid/s_bresp hold until s_bready is sampled high. A pending response blocks the next commit; buffers stay full and the corresponding readies stay low.
- Read path: s_arready = !s_rvalid.
  - On AR handshake: s_rdata <= reg[s_araddr], s_rresp <= OKAY, s_rvalid <= 1.
  - s_rdata is held stable until the R handshake completes.
- Read and write paths are fully independent. If a commit and an AR handshake to the same register fall on the same edge, the read returns the pre-write value.
- reg_out reflects register contents as of the current cycle, i.e. it is updated by the commit edge.

## Timing
- Reset values: s_awready=1, s_wready=1, s_arready=1, s_bvalid=0, s_bresp=00, s_rvalid=0, s_rdata=0, s_rresp=00, all registers 0, reg_out=0, full flags 0.
- Reset asserted mid-transaction aborts it: buffers are cleared and no response is issued.
- Write latency: with E the edge completing the later of AW/W, the commit and s_bvalid rise occur at E+1 (if B is free).
- Readies reopen after the commit edge. Best-case throughput: one write per 2 cycles.
- Read latency: s_rvalid rises at the AR handshake edge. A back-to-back read is possible at the edge after the R handshake.
- Readies are registered-state functions only; there are no combinational paths from any input valid/ready to any output.

## Structure
- Shared `axi4lite_pkg`: RESP_OKAY=2'b00, RESP_SLVERR=2'b10; a PROT width constant of 3.
- One sub-module, `axi4lite_regfile`: storage, per-lane strobe merge, RO gating, a combinational read port, and the flat reg_out.
- Handshake and buffer logic stays in the top.

## Test plan
- Reset, then write idx 2 data 0x04 strb 1 with AW and W in the same cycle → BVALID at E+1, bresp 00. Then read idx 2 → rdata 0x04, rresp 00.
- W two cycles before AW (idx 1, 0xA5) → wready low after W, no BVALID until AW plus one edge, reg_out[15:8]=0xA5.
- Hold bready=0 across two writes → second write is buffered, awready/wready stay low, second BVALID only after the first B handshake; both values land.
- RO_MASK=4'b1000: write idx 3 0xFF → bresp 10, read idx 3 returns 0x00.
- Write with strb=0 → bresp 00, register unchanged. Commit and read of the same index on the same edge → old value returned.
- Assert rst_n low while aw_full=1 → all outputs reach reset values, no BVALID after release.

Source files
------------

// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite constants: response codes and protection field width.
package axi4lite_pkg;
  localparam int PROT_W = 3;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axi4lite_regfile.sv
// Register storage behind the AXI4-Lite responder: byte-lane merge, read-only gating,
// combinational read port and a flat export of every register.
module axi4lite_regfile #(
  parameter int                          ADDR_WIDTH = 2,
  parameter int                          DATA_WIDTH = 8,
  parameter logic [(1<<ADDR_WIDTH)-1:0]  RO_MASK    = '0
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    i_we,
  input  logic [ADDR_WIDTH-1:0]                   i_waddr,
  input  logic [DATA_WIDTH-1:0]                   i_wdata,
  input  logic [DATA_WIDTH/8-1:0]                 i_wstrb,
  output logic                                    o_wr_ro,
  input  logic [ADDR_WIDTH-1:0]                   i_raddr,
  output logic [DATA_WIDTH-1:0]                   o_rdata,
  output logic [DATA_WIDTH*(1<<ADDR_WIDTH)-1:0]   o_reg_out
);
  localparam int NREG  = 1 << ADDR_WIDTH;
  localparam int NLANE = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [NREG];

  assign o_wr_ro = RO_MASK[i_waddr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we && !o_wr_ro) begin
      for (int b = 0; b < NLANE; b++) begin
        if (i_wstrb[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign o_reg_out[g*DATA_WIDTH +: DATA_WIDTH] = r_mem[g];
  end
endmodule

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite responder: one-entry AW and W holding buffers feeding a commit into the
// register file, plus an independent single-outstanding read path.
module axi4lite_slave_regs
  import axi4lite_pkg::*;
#(
  parameter int                          ADDR_WIDTH = 2,
  parameter int                          DATA_WIDTH = 8,
  parameter logic [(1<<ADDR_WIDTH)-1:0]  RO_MASK    = '0
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    s_awvalid,
  output logic                                    s_awready,
  input  logic [ADDR_WIDTH-1:0]                   s_awaddr,
  input  logic [PROT_W-1:0]                       s_awprot,
  input  logic                                    s_wvalid,
  output logic                                    s_wready,
  input  logic [DATA_WIDTH-1:0]                   s_wdata,
  input  logic [DATA_WIDTH/8-1:0]                 s_wstrb,
  output logic                                    s_bvalid,
  input  logic                                    s_bready,
  output logic [1:0]                              s_bresp,
  input  logic                                    s_arvalid,
  output logic                                    s_arready,
  input  logic [ADDR_WIDTH-1:0]                   s_araddr,
  input  logic [PROT_W-1:0]                       s_arprot,
  output logic                                    s_rvalid,
  input  logic                                    s_rready,
  output logic [DATA_WIDTH-1:0]                   s_rdata,
  output logic [1:0]                              s_rresp,
  output logic [DATA_WIDTH*(1<<ADDR_WIDTH)-1:0]   reg_out
);
  logic                    r_aw_full;
  logic [ADDR_WIDTH-1:0]   r_aw_addr;
  logic                    r_w_full;
  logic [DATA_WIDTH-1:0]   r_w_data;
  logic [DATA_WIDTH/8-1:0] r_w_strb;
  logic                    r_bvalid;
  resp_t                   r_bresp;
  logic                    r_rvalid;
  logic [DATA_WIDTH-1:0]   r_rdata;

  logic                    w_aw_hs;
  logic                    w_w_hs;
  logic                    w_ar_hs;
  logic                    w_commit;
  logic                    w_wr_ro;
  logic [DATA_WIDTH-1:0]   w_rd_data;
  logic                    w_unused_prot;

  // Protection attributes carry no meaning for this register file.
  assign w_unused_prot = ^{s_awprot, s_arprot};

  assign s_awready = !r_aw_full;
  assign s_wready  = !r_w_full;
  assign s_arready = !r_rvalid;
  assign s_bvalid  = r_bvalid;
  assign s_bresp   = r_bresp;
  assign s_rvalid  = r_rvalid;
  assign s_rdata   = r_rdata;
  assign s_rresp   = RESP_OKAY;

  assign w_aw_hs  = s_awvalid && s_awready;
  assign w_w_hs   = s_wvalid && s_wready;
  assign w_ar_hs  = s_arvalid && s_arready;
  assign w_commit = r_aw_full && r_w_full && !r_bvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_full <= 1'b0;
      r_aw_addr <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
    end else begin
      if (w_commit) begin
        r_aw_full <= 1'b0;
      end else if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_addr <= s_awaddr;
      end
      if (w_commit) begin
        r_w_full <= 1'b0;
      end else if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_w_data <= s_wdata;
        r_w_strb <= s_wstrb;
      end
    end
  end

  // The response is held until accepted; a pending response stalls the next commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_wr_ro ? RESP_SLVERR : RESP_OKAY;
    end else if (s_bready) begin
      r_bvalid <= 1'b0;
    end
  end

  // Read data is captured from the pre-commit contents, so a same-edge write is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
    end else if (s_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  axi4lite_regfile #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .RO_MASK    (RO_MASK)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_commit),
    .i_waddr   (r_aw_addr),
    .i_wdata   (r_w_data),
    .i_wstrb   (r_w_strb),
    .o_wr_ro   (w_wr_ro),
    .i_raddr   (s_araddr),
    .o_rdata   (w_rd_data),
    .o_reg_out (reg_out)
  );
endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Directed scoreboard bench for axi4lite_slave_regs with register 3 read-only.
module tb_axi4lite_slave_regs;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_awvalid, s_awready;
  logic [1:0]  s_awaddr;
  logic [2:0]  s_awprot;
  logic        s_wvalid, s_wready;
  logic [7:0]  s_wdata;
  logic [0:0]  s_wstrb;
  logic        s_bvalid, s_bready;
  logic [1:0]  s_bresp;
  logic        s_arvalid, s_arready;
  logic [1:0]  s_araddr;
  logic [2:0]  s_arprot;
  logic        s_rvalid, s_rready;
  logic [7:0]  s_rdata;
  logic [1:0]  s_rresp;
  logic [31:0] reg_out;

  int n_chk = 0;
  int n_err = 0;
  logic [1:0] bq[$];
  logic [7:0] rq[$];

  always #5 clk = ~clk;

  axi4lite_slave_regs #(
    .ADDR_WIDTH (2),
    .DATA_WIDTH (8),
    .RO_MASK    (4'b1000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_awaddr  (s_awaddr),
    .s_awprot  (s_awprot),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_bresp   (s_bresp),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_araddr  (s_araddr),
    .s_arprot  (s_arprot),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .reg_out   (reg_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response handshake pops the oldest expected response.
  always @(negedge clk) begin
    if (rst_n && s_bvalid && s_bready) begin
      if (bq.size() == 0) chk("b_unexpected", 32'(s_bresp), 32'hFFFF_FFFF);
      else chk("bresp", 32'(s_bresp), 32'(bq.pop_front()));
    end
    if (rst_n && s_rvalid && s_rready) begin
      if (rq.size() == 0) chk("r_unexpected", 32'(s_rdata), 32'hFFFF_FFFF);
      else begin
        chk("rdata", 32'(s_rdata), 32'(rq.pop_front()));
        chk("rresp", 32'(s_rresp), 32'h0);
      end
    end
  end

  // AW and W presented together; returns just after the accepting edge.
  task automatic aw_w(input logic [1:0] idx, input logic [7:0] d, input logic s);
    int n = 0;
    s_awvalid = 1'b1; s_awaddr = idx;
    s_wvalid  = 1'b1; s_wdata  = d; s_wstrb = s;
    while (!(s_awready && s_wready) && n < 50) begin cyc(); n++; end
    if (n >= 50) chk("aw_w_timeout", 32'(n), 32'h0);
    cyc();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
  endtask

  task automatic rd(input logic [1:0] idx, input logic [7:0] exp);
    int n = 0;
    rq.push_back(exp);
    s_arvalid = 1'b1; s_araddr = idx;
    while (!s_arready && n < 50) begin cyc(); n++; end
    if (n >= 50) chk("ar_timeout", 32'(n), 32'h0);
    cyc();
    s_arvalid = 1'b0;
    chk("rvalid_at_ar_edge", 32'(s_rvalid), 32'h1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_awready"}, 32'(s_awready), 32'h1);
    chk({tag, "_wready"},  32'(s_wready),  32'h1);
    chk({tag, "_arready"}, 32'(s_arready), 32'h1);
    chk({tag, "_bvalid"},  32'(s_bvalid),  32'h0);
    chk({tag, "_bresp"},   32'(s_bresp),   32'h0);
    chk({tag, "_rvalid"},  32'(s_rvalid),  32'h0);
    chk({tag, "_rdata"},   32'(s_rdata),   32'h0);
    chk({tag, "_rresp"},   32'(s_rresp),   32'h0);
    chk({tag, "_reg_out"}, reg_out,        32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    s_awvalid = 1'b0; s_awaddr = '0; s_awprot = 3'b000;
    s_wvalid = 1'b0; s_wdata = '0; s_wstrb = '0;
    s_arvalid = 1'b0; s_araddr = '0; s_arprot = 3'b000;
    s_bready = 1'b1; s_rready = 1'b1;
    repeat (3) cyc();
    chk_reset_state("rst");
    rst_n = 1'b1;
    cyc();

    // Same-cycle AW/W to idx 2, then read it back
    bq.push_back(2'b00);
    aw_w(2'd2, 8'h04, 1'b1);
    chk("t1_bvalid_E", 32'(s_bvalid), 32'h0);
    chk("t1_awready_E", 32'(s_awready), 32'h0);
    cyc();
    chk("t1_bvalid_E1", 32'(s_bvalid), 32'h1);
    chk("t1_reg2", 32'(reg_out[23:16]), 32'h04);
    rd(2'd2, 8'h04);
    repeat (2) cyc();

    // W two cycles ahead of AW
    bq.push_back(2'b00);
    s_wvalid = 1'b1; s_wdata = 8'hA5; s_wstrb = 1'b1;
    cyc();
    s_wvalid = 1'b0;
    chk("t2_wready_low", 32'(s_wready), 32'h0);
    chk("t2_bvalid_w", 32'(s_bvalid), 32'h0);
    cyc();
    chk("t2_bvalid_wait", 32'(s_bvalid), 32'h0);
    s_awvalid = 1'b1; s_awaddr = 2'd1;
    cyc();
    s_awvalid = 1'b0;
    chk("t2_bvalid_aw", 32'(s_bvalid), 32'h0);
    cyc();
    chk("t2_bvalid_E1", 32'(s_bvalid), 32'h1);
    chk("t2_reg1", 32'(reg_out[15:8]), 32'hA5);
    repeat (2) cyc();

    // Two writes while B is held back
    s_bready = 1'b0;
    bq.push_back(2'b00);
    bq.push_back(2'b00);
    aw_w(2'd0, 8'h11, 1'b1);
    aw_w(2'd1, 8'h22, 1'b1);
    for (int i = 0; i < 2; i++) begin
      chk("t3_awready_stall", 32'(s_awready), 32'h0);
      chk("t3_wready_stall", 32'(s_wready), 32'h0);
      chk("t3_bvalid_held", 32'(s_bvalid), 32'h1);
      chk("t3_reg1_old", 32'(reg_out[15:8]), 32'hA5);
      cyc();
    end
    chk("t3_reg0", 32'(reg_out[7:0]), 32'h11);
    s_bready = 1'b1;
    cyc();
    chk("t3_bvalid_gap", 32'(s_bvalid), 32'h0);
    cyc();
    chk("t3_bvalid_second", 32'(s_bvalid), 32'h1);
    chk("t3_reg1_new", 32'(reg_out[15:8]), 32'h22);
    repeat (2) cyc();

    // Read-only register 3
    bq.push_back(2'b10);
    aw_w(2'd3, 8'hFF, 1'b1);
    cyc();
    chk("t4_reg3", 32'(reg_out[31:24]), 32'h00);
    rd(2'd3, 8'h00);
    repeat (2) cyc();

    // Strobe-less write leaves idx 2 alone
    bq.push_back(2'b00);
    aw_w(2'd2, 8'hEE, 1'b0);
    cyc();
    chk("t5_reg2_kept", 32'(reg_out[23:16]), 32'h04);
    rd(2'd2, 8'h04);
    repeat (2) cyc();

    // Read on the commit edge returns the old value
    bq.push_back(2'b00);
    aw_w(2'd2, 8'h5A, 1'b1);
    rq.push_back(8'h04);
    s_arvalid = 1'b1; s_araddr = 2'd2;
    cyc();
    s_arvalid = 1'b0;
    chk("t6_reg2_new", 32'(reg_out[23:16]), 32'h5A);
    cyc();
    rd(2'd2, 8'h5A);
    repeat (2) cyc();

    // Reset with AW buffered aborts the write
    s_awvalid = 1'b1; s_awaddr = 2'd0;
    cyc();
    s_awvalid = 1'b0;
    chk("t7_aw_full", 32'(s_awready), 32'h0);
    rst_n = 1'b0;
    #1;
    chk_reset_state("t7_rst");
    cyc();
    rst_n = 1'b1;
    s_wvalid = 1'b1; s_wdata = 8'h77; s_wstrb = 1'b1;
    cyc();
    s_wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t7_no_bvalid", 32'(s_bvalid), 32'h0);
      cyc();
    end
    chk("t7_awready", 32'(s_awready), 32'h1);
    chk("t7_reg_out", reg_out, 32'h0);

    repeat (3) cyc();
    chk("b_queue_empty", 32'(bq.size()), 32'h0);
    chk("r_queue_empty", 32'(rq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
